// File: rtl/std_round_robin_arbiter.sv
// Registered round-robin arbiter with grant lock-until-ack.
// Produces a onehot-or-zero grant vector plus its binary index. Both come
// straight from flops, so there is no combinational path from any input to
// any output.
//
// Handshake: a grant is presented while o_valid=1 and is held unchanged
// until i_ack=1 is sampled at a rising edge. On that edge priority moves to
// the index after the acknowledged requester, and a new grant may be issued
// in the same edge (no idle bubble). i_ack sampled while o_valid=0 has no
// effect.
module std_round_robin_arbiter #(
  parameter int REQUESTS = 8,
  localparam int INDEX_WIDTH = $clog2(REQUESTS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic [REQUESTS-1:0]    i_request,
  input  logic                   i_ack,
  output logic                   o_valid,
  output logic [REQUESTS-1:0]    o_grant,
  output logic [INDEX_WIDTH-1:0] o_grant_index
);

  // The FSM state is directly observable as o_valid (GRANTED <=> o_valid=1).
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } state_e;

  state_e                 state_q;
  logic [REQUESTS-1:0]    grant_q;
  logic [INDEX_WIDTH-1:0] index_q;
  logic [INDEX_WIDTH-1:0] ptr_q;

  logic [INDEX_WIDTH-1:0] ack_ptr_d;
  logic [INDEX_WIDTH-1:0] base_ptr_d;
  logic                   sel_found_d;
  logic [INDEX_WIDTH-1:0] sel_idx_d;
  logic [REQUESTS-1:0]    sel_onehot_d;

  // Priority start: the slot after the current grant when re-arbitrating on
  // ack, otherwise the stored pointer. The wrap is explicit so that
  // non-power-of-two sizes never produce an out-of-range index.
  always_comb begin
    if (index_q == INDEX_WIDTH'(REQUESTS - 1)) begin
      ack_ptr_d = '0;
    end else begin
      ack_ptr_d = index_q + INDEX_WIDTH'(1);
    end
    base_ptr_d = (state_q == ST_GRANTED) ? ack_ptr_d : ptr_q;
  end

  // Search upward from base_ptr_d for the first set request, wrapping at REQUESTS.
  always_comb begin
    int                     pos;
    logic [INDEX_WIDTH-1:0] pos_w;
    pos          = 0;
    pos_w        = '0;
    sel_found_d  = 1'b0;
    sel_idx_d    = '0;
    sel_onehot_d = '0;
    for (int k = 0; k < REQUESTS; k++) begin
      pos = int'(base_ptr_d) + k;
      if (pos >= REQUESTS) begin
        pos = pos - REQUESTS;
      end
      pos_w = INDEX_WIDTH'(pos);
      if (!sel_found_d && i_request[pos_w]) begin
        sel_found_d = 1'b1;
        sel_idx_d   = pos_w;
      end
    end
    if (sel_found_d) begin
      sel_onehot_d[sel_idx_d] = 1'b1;
    end
  end

  // Grant FSM: issue from IDLE, hold while unacknowledged, re-arbitrate on ack.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      index_q <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_en && sel_found_d) begin
            state_q <= ST_GRANTED;
            grant_q <= sel_onehot_d;
            index_q <= sel_idx_d;
          end
        end
        ST_GRANTED: begin
          if (i_ack) begin
            ptr_q <= ack_ptr_d;
            if (i_en && sel_found_d) begin
              grant_q <= sel_onehot_d;
              index_q <= sel_idx_d;
            end else begin
              state_q <= ST_IDLE;
              grant_q <= '0;
              index_q <= '0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          index_q <= '0;
        end
      endcase
    end
  end

  assign o_valid       = (state_q == ST_GRANTED);
  assign o_grant       = grant_q;
  assign o_grant_index = index_q;

endmodule

// File: tb/tb_std_round_robin_arbiter.sv
// Testbench for std_round_robin_arbiter: a 4-requester and a 5-requester
// instance driven side by side, checked against a behavioural model through
// per-instance expected queues.
module tb_std_round_robin_arbiter;

  // ---------------- clock / reset ----------------
  logic       i_clk;
  logic       i_rst;
  logic       i_en;
  logic       i_ack;
  logic [3:0] req4;
  logic [4:0] req5;

  logic       v4;
  logic [3:0] g4;
  logic [1:0] x4;
  logic       v5;
  logic [4:0] g5;
  logic [2:0] x5;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  std_round_robin_arbiter #(.REQUESTS(4)) dut4 (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_en          (i_en),
    .i_request     (req4),
    .i_ack         (i_ack),
    .o_valid       (v4),
    .o_grant       (g4),
    .o_grant_index (x4)
  );

  std_round_robin_arbiter #(.REQUESTS(5)) dut5 (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_en          (i_en),
    .i_request     (req5),
    .i_ack         (i_ack),
    .o_valid       (v5),
    .o_grant       (g5),
    .o_grant_index (x5)
  );

  // ---------------- scoreboard state ----------------
  // Expected word: {valid, grant[4:0], index[2:0]}
  logic [8:0] exp_q4[$];
  logic [8:0] exp_q5[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_valid[2];
  int m_idx[2];
  int m_ptr[2];

  function automatic int sel(input int req, input int ptr, input int n);
    for (int k = 0; k < n; k++) begin
      int j;
      j = (ptr + k) % n;
      if (((req >> j) & 1) == 1) return j;
    end
    return -1;
  endfunction

  task automatic model_step(input int l, input int n, input bit rst,
                            input bit en, input bit ack, input int req);
    int s;
    if (rst) begin
      m_valid[l] = 0;
      m_idx[l]   = 0;
      m_ptr[l]   = 0;
    end else if (m_valid[l] == 0) begin
      s = sel(req, m_ptr[l], n);
      if (en && s >= 0) begin
        m_valid[l] = 1;
        m_idx[l]   = s;
      end
    end else if (ack) begin
      m_ptr[l] = (m_idx[l] + 1) % n;
      s = sel(req, m_ptr[l], n);
      if (en && s >= 0) begin
        m_idx[l] = s;
      end else begin
        m_valid[l] = 0;
        m_idx[l]   = 0;
      end
    end
  endtask

  function automatic logic [8:0] model_word(input int l);
    logic [4:0] g;
    g = '0;
    if (m_valid[l] != 0) g[m_idx[l]] = 1'b1;
    return {m_valid[l] != 0, g, 3'(m_idx[l])};
  endfunction

  // ---------------- driver ----------------
  // Applies one cycle of inputs shortly after a rising edge and queues the
  // outputs expected after the following edge.
  task automatic step(input bit rst, input bit en, input bit ack,
                      input logic [3:0] r4, input logic [4:0] r5);
    @(posedge i_clk);
    #2;
    i_rst = rst;
    i_en  = en;
    i_ack = ack;
    req4  = r4;
    req5  = r5;
    model_step(0, 4, rst, en, ack, int'(r4));
    exp_q4.push_back(model_word(0));
    model_step(1, 5, rst, en, ack, int'(r5));
    exp_q5.push_back(model_word(1));
  endtask

  // ---------------- monitor ----------------
  always @(posedge i_clk) begin
    logic [8:0] e;
    logic [8:0] a;
    #1;
    if (exp_q4.size() > 0) begin
      e = exp_q4.pop_front();
      a = {v4, 1'b0, g4, 1'b0, x4};
      chk("dut4_outputs", int'(a), int'(e));
    end
    if (exp_q5.size() > 0) begin
      e = exp_q5.pop_front();
      a = {v5, g5, x5};
      chk("dut5_outputs", int'(a), int'(e));
    end
    chk("dut4_onehot0", int'($onehot0(g4)), 1);
    chk("dut4_valid_eq_or", int'(v4), int'(|g4));
    if (v4) chk("dut4_index_bit", int'(g4[x4]), 1);
    chk("dut5_onehot0", int'($onehot0(g5)), 1);
    chk("dut5_valid_eq_or", int'(v5), int'(|g5));
    if (v5) chk("dut5_index_bit", int'(g5[x5]), 1);
    chk("dut5_index_range", int'(x5 < 3'd5), 1);
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int l = 0; l < 2; l++) begin
      m_valid[l] = 0;
      m_idx[l]   = 0;
      m_ptr[l]   = 0;
    end
    i_rst = 1'b1;
    i_en  = 1'b0;
    i_ack = 1'b0;
    req4  = '0;
    req5  = '0;

    // Reset then idle
    repeat (2) step(1, 1, 0, 4'b0000, 5'b00000);
    repeat (3) step(0, 1, 0, 4'b0000, 5'b00000);

    // Single request held without ack, then request dropped, then acked
    repeat (5) step(0, 1, 0, 4'b0100, 5'b00100);
    repeat (2) step(0, 1, 0, 4'b0000, 5'b00000);
    step(0, 1, 1, 4'b0000, 5'b00000);
    step(0, 1, 0, 4'b0000, 5'b00000);

    // Full rotation (4 and 5 requesters)
    step(1, 1, 0, 4'b0000, 5'b00000);
    repeat (12) step(0, 1, 1, 4'b1111, 5'b11111);

    // Sparse rotation with wrap, then a lone requester re-granted
    step(1, 1, 0, 4'b0000, 5'b00000);
    repeat (6) step(0, 1, 1, 4'b1001, 5'b10001);
    repeat (4) step(0, 1, 1, 4'b0001, 5'b00001);

    // Enable gating
    step(1, 1, 0, 4'b0000, 5'b00000);
    step(0, 1, 0, 4'b0010, 5'b00010);
    repeat (3) step(0, 0, 0, 4'b1111, 5'b11111);
    step(0, 0, 1, 4'b1111, 5'b11111);
    step(0, 1, 0, 4'b1111, 5'b11111);
    step(0, 1, 0, 4'b1111, 5'b11111);

    // Reset mid-grant clears the pointer
    step(1, 1, 0, 4'b0000, 5'b00000);
    step(0, 1, 0, 4'b1000, 5'b01000);
    step(0, 1, 0, 4'b1000, 5'b01000);
    step(1, 1, 0, 4'b1111, 5'b11111);
    repeat (2) step(0, 1, 0, 4'b1111, 5'b11111);

    // ack while idle must be ignored
    step(1, 1, 0, 4'b0000, 5'b00000);
    repeat (3) step(0, 1, 1, 4'b0000, 5'b00000);
    step(0, 1, 0, 4'b0100, 5'b00100);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      bit         r_rst;
      bit         r_en;
      bit         r_ack;
      logic [4:0] r5;
      logic [3:0] r4;
      r_rst = ($urandom_range(0, 59) == 0);
      r_en  = ($urandom_range(0, 4) != 0);
      r_ack = ($urandom_range(0, 2) != 0);
      r4    = 4'($urandom_range(0, 15));
      r5    = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) r4 = 4'b0001 << $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) r5 = 5'b00001 << $urandom_range(0, 4);
      step(r_rst, r_en, r_ack, r4, r5);
    end

    // Drain: let the monitor consume the remaining expectations
    repeat (3) @(posedge i_clk);
    #3;
    chk("dut4_queue_drained", exp_q4.size(), 0);
    chk("dut5_queue_drained", exp_q5.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/std_round_robin_arbiter.md
Name: std_round_robin_arbiter

Overview:
- Registered round-robin arbiter that produces a one-hot grant vector plus its binary index.
- Sits directly upstream of the team's binary encoder: the one-hot grant vector is guaranteed onehot-or-zero, which is the encoder's input contract.
- Grants are held (locked) until the consumer acknowledges them, so downstream muxes see a stable selection.

Parameters:
- REQUESTS, 8, number of requesters; legal range is 2 or greater.
- INDEX_WIDTH, $clog2(REQUESTS), derived localparam; width of the binary index.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_en  input  1  arbitration enable; when low, no new grant is issued.
- i_request  input  REQUESTS  request vector; bit k set means requester k wants the resource.
- i_ack  input  1  consumer accepts the current grant; meaningful only while o_valid is 1.
- o_valid  output  1  a grant is active.
- o_grant  output  REQUESTS  one-hot grant; all zero when o_valid is 0.
- o_grant_index  output  INDEX_WIDTH  binary position of the set bit in o_grant; 0 when o_valid is 0.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (i_clk, i_rst).
- All outputs are registered. There is no combinational path from any input to any output.
- Reset (i_rst=1 at a clock edge):
  - o_valid=0, o_grant=0, o_grant_index=0, priority pointer ptr=0.
  - Reset dominates every other input.
  - Reset mid-grant drops the grant with no ack required.
- State: two states, IDLE (o_valid=0) and GRANTED (o_valid=1). The internal pointer ptr has width INDEX_WIDTH.
- Selection function sel(req, ptr): the first set bit of req found by searching upward from index ptr and wrapping from REQUESTS-1 to 0.
- IDLE:
  - If i_en=1 and |i_request, then next cycle: GRANTED, o_grant=onehot(sel(i_request, ptr)), o_grant_index=sel(...). Latency from request to grant is 1 cycle.
  - Otherwise stay in IDLE.
- GRANTED with i_ack=0:
  - o_grant, o_grant_index and o_valid hold unchanged.
  - Holding is unaffected by i_request deasserting and by i_en going low.
- GRANTED with i_ack=1:
  - ptr <= (o_grant_index+1) mod REQUESTS.
  - In the same edge, re-arbitrate using the current i_request with the updated pointer, i.e. sel(i_request, (o_grant_index+1) mod REQUESTS).
  - If i_en=1 and a request exists, move directly to the new grant (back-to-back, no idle bubble). The same requester may be re-granted if it is the only one requesting.
  - Otherwise go to IDLE.
- ptr changes only on ack or reset. A grant that has not been acknowledged never advances priority.
- Wrap-around: the index after REQUESTS-1 is 0.
  - For non-power-of-two REQUESTS, ptr must never take a value of REQUESTS or above. The mod is explicit, not a natural overflow.
- i_ack while IDLE is ignored and has no state effect.
- Invariants, checked by the bench every cycle:
  - o_grant is onehot-or-zero.
  - o_valid equals |o_grant.
  - When o_valid=1, o_grant[o_grant_index]=1.
- Fairness: with all requesters continuously asserting and i_ack=1 on every grant cycle, grants rotate 0,1,...,REQUESTS-1,0,... with one grant per cycle.

Test Plan:
- Reset then idle (REQUESTS=4): i_rst=1 for 2 cycles, then i_request=0 -> o_valid=0, o_grant=0000, o_grant_index=0 throughout.
- Single request and hold (REQUESTS=4): i_request=0100, i_ack=0 for 5 cycles -> 1 cycle after the request, o_grant=0100 and o_grant_index=2, stable for all 5 cycles. Drop i_request while still unacked -> grant still held.
- Rotation (REQUESTS=4):
  - i_request=1111, i_ack=1 every cycle -> o_grant_index sequence 0,1,2,3,0,1 on consecutive cycles, o_valid stays 1.
  - With REQUESTS=5 -> sequence 0..4,0 with no out-of-range index.
- Sparse rotation and wrap (REQUESTS=4):
  - i_request=1001, i_ack=1 -> indices 0,3,0,3.
  - Then i_request=0001 only -> index 0 repeatedly with no bubble.
- Enable gating (REQUESTS=4):
  - Grant active at index 1, i_en=0, i_ack=0 -> grant held.
  - Assert i_ack with i_en=0 -> next cycle o_valid=0, ptr=2.
  - Set i_en=1 with i_request=1111 -> grant index 2 one cycle later.
- Reset mid-grant (REQUESTS=4): grant at index 3, pulse i_rst for 1 cycle, i_request=1111 -> o_valid=0 during reset. The first grant after reset is index 0 (ptr cleared).
